fifo_uart_tx: RTL and testbench

Downstream consumer of the 8-bit synchronous FIFO. When the FIFO is non-empty it pops one byte and serialises it as an asynchronous UART frame: start bit, 8 data bits LSB first, optional even parity, and one stop bit. It is the FIFO's only reader and drives the FIFO's `rd_en` directly.

---
 rtl/fifo_uart_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 44 ++++
 rtl/fifo_uart_tx.sv | 147 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared state encoding, widths and parity helper for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } tx_state_t;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        even_parity = ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter; flags the last and second-to-last cycle of each UART bit.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Next count: wraps at the end of a bit, forced to zero on restart.
    always_comb begin
        cnt_nxt_s = CNT_ZERO;
        if (restart || (cnt_r == CNT_LAST)) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Counter plus flags decoded from the next count so they line up with cnt_r.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r       <= CNT_ZERO;
            bit_end     <= 1'b0;
            bit_pre_end <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            bit_end     <= (cnt_nxt_s == CNT_LAST);
            bit_pre_end <= (cnt_nxt_s == CNT_PRE);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the upstream FIFO and serialises them as 8N1 / 8E1 UART frames.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_W - 1);

    tx_state_t         state_r;
    logic [DATA_W-1:0] shreg_r;
    logic [2:0]        bit_idx_r;
    logic              parity_r;
    logic              restart_s;
    logic              start_ok_s;
    logic              bit_end_s;
    logic              bit_pre_end_s;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .restart     (restart_s),
        .bit_end     (bit_end_s),
        .bit_pre_end (bit_pre_end_s)
    );

    // Hold the timer at zero outside timed states so every bit starts at count 0.
    always_comb begin
        restart_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_FETCH, ST_LOAD: restart_s = 1'b1;
            default:                    restart_s = bit_end_s;
        endcase
    end

    // A new frame may begin only when permitted and the FIFO holds a byte.
    always_comb begin
        start_ok_s = 1'b0;
        if (enable && !fifo_empty) begin
            start_ok_s = 1'b1;
        end else begin
            start_ok_s = 1'b0;
        end
    end

    // Frame sequencer; every output is set on the edge that enters its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            shreg_r    <= {DATA_W{1'b0}};
            bit_idx_r  <= 3'd0;
            parity_r   <= 1'b0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            frame_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (start_ok_s) begin
                        state_r    <= ST_FETCH;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_LOAD;
                end
                ST_LOAD: begin
                    // FIFO data is valid the cycle after the read strobe.
                    shreg_r   <= fifo_data;
                    parity_r  <= even_parity(fifo_data);
                    bit_idx_r <= 3'd0;
                    state_r   <= ST_START;
                    tx        <= 1'b0;
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r <= ST_DATA;
                        tx      <= shreg_r[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        if (bit_idx_r == LAST_IDX) begin
                            if (PARITY_EN != 0) begin
                                state_r <= ST_PARITY;
                                tx      <= parity_r;
                            end else begin
                                state_r <= ST_STOP;
                                tx      <= 1'b1;
                            end
                        end else begin
                            shreg_r   <= {1'b0, shreg_r[DATA_W-1:1]};
                            tx        <= shreg_r[1];
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        state_r <= ST_STOP;
                        tx      <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_pre_end_s) begin
                        frame_done <= 1'b1;
                    end
                    if (bit_end_s) begin
                        if (start_ok_s) begin
                            state_r    <= ST_FETCH;
                            fifo_rd_en <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Two transmitters (no parity / even parity) fed by behavioural FIFOs, with a bit-centre UART receiver.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] enable;
    logic [1:0] fifo_empty;
    logic [1:0] fifo_rd_en;
    logic [1:0] tx_s;
    logic [1:0] busy_s;
    logic [1:0] frame_done_s;
    logic [1:0] wr_en;
    logic [7:0] wr_data   [2];
    logic [7:0] fifo_dout [2];
    logic [7:0] mem       [2][16];
    logic [3:0] wp        [2];
    logic [3:0] rp        [2];
    logic [4:0] fcnt      [2];

    int checks  = 0;
    int errors  = 0;
    int rd_cnt  [2] = '{0, 0};
    int rx_err  [2] = '{0, 0};
    int rd_viol = 0;
    logic [7:0] rx_q0 [$];
    logic [7:0] rx_q1 [$];

    typedef struct {
        int          unit;
        logic [7:0]  data;
        int          nbits;
        logic [10:0] frame;   // frame[i] = line level during bit period i
    } vec_t;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
        .clk(clk), .reset_n(rst_n), .enable(enable[0]), .fifo_empty(fifo_empty[0]),
        .fifo_data(fifo_dout[0]), .fifo_rd_en(fifo_rd_en[0]), .tx(tx_s[0]),
        .busy(busy_s[0]), .frame_done(frame_done_s[0]));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
        .clk(clk), .reset_n(rst_n), .enable(enable[1]), .fifo_empty(fifo_empty[1]),
        .fifo_data(fifo_dout[1]), .fifo_rd_en(fifo_rd_en[1]), .tx(tx_s[1]),
        .busy(busy_s[1]), .frame_done(frame_done_s[1]));

    // Behavioural 16-deep synchronous FIFOs, data_out valid the cycle after rd_en.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                wp[k] <= 4'd0; rp[k] <= 4'd0; fcnt[k] <= 5'd0; fifo_dout[k] <= 8'h00;
            end else begin
                if (wr_en[k] && fcnt[k] != 5'd16) begin
                    mem[k][wp[k]] <= wr_data[k];
                    wp[k] <= wp[k] + 4'd1;
                end
                if (fifo_rd_en[k] && fcnt[k] != 5'd0) begin
                    fifo_dout[k] <= mem[k][rp[k]];
                    rp[k] <= rp[k] + 4'd1;
                end
                fcnt[k] <= fcnt[k] + {4'd0, (wr_en[k] && fcnt[k] != 5'd16)}
                                   - {4'd0, (fifo_rd_en[k] && fcnt[k] != 5'd0)};
            end
        end
    end

    assign fifo_empty = {(fcnt[1] == 5'd0), (fcnt[0] == 5'd0)};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // UART receiver: detect the start edge, sample each bit at its centre.
    task automatic rx_monitor(input int k);
        int          cnt;
        bit          active;
        logic [10:0] bits;
        int          len;
        len = (k == 0) ? 10 : 11;
        active = 1'b0; cnt = 0; bits = 11'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx_s[k] == 1'b0) begin active = 1'b1; cnt = 0; end
            end else begin
                cnt++;
                if (cnt % CPB == CPB / 2) bits[cnt / CPB] = tx_s[k];
                if (cnt == (len - 1) * CPB + CPB / 2) begin
                    active = 1'b0;
                    if (bits[0] != 1'b0 || bits[len-1] != 1'b1) rx_err[k]++;
                    if (k == 1 && bits[9] != ^bits[8:1]) rx_err[k]++;
                    if (k == 0) rx_q0.push_back(bits[8:1]);
                    else        rx_q1.push_back(bits[8:1]);
                end
            end
        end
    endtask

    initial rx_monitor(0);
    initial rx_monitor(1);

    // Read-strobe monitor: counts pulses, flags reads of an empty FIFO or multi-cycle strobes.
    initial begin
        logic [1:0] prev_rd;
        prev_rd = 2'b00;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (fifo_rd_en[k] === 1'b1) begin
                    rd_cnt[k]++;
                    if (fifo_empty[k] || prev_rd[k]) rd_viol++;
                end
                prev_rd[k] = fifo_rd_en[k];
            end
        end
    end

    task automatic push(input int k, input logic [7:0] b);
        @(negedge clk);
        wr_en[k] = 1'b1; wr_data[k] = b;
        @(negedge clk);
        wr_en[k] = 1'b0;
    endtask

    task automatic clear_rx();
        rx_q0.delete(); rx_q1.delete();
    endtask

    // Single frame: latency, cycle-exact waveform, frame_done placement, decoded byte.
    task automatic run_vector(input int k, input logic [7:0] d, input int nbits, input logic [10:0] frame);
        int rd0, lat, bad_tx, bad_fd, bad_busy, last;
        logic [7:0] got;
        rd0 = rd_cnt[k]; clear_rx();
        push(k, d);
        lat = 0;
        while (tx_s[k] !== 1'b0 && lat < 30) begin @(negedge clk); lat++; end
        chk($sformatf("latency_u%0d_%02h", k, d), lat, 3);
        bad_tx = 0; bad_fd = 0; bad_busy = 0; last = nbits * CPB - 1;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge clk);
            if (tx_s[k] !== frame[c / CPB]) bad_tx++;
            if (frame_done_s[k] !== ((c == last) ? 1'b1 : 1'b0)) bad_fd++;
            if (busy_s[k] !== 1'b1) bad_busy++;
        end
        chk($sformatf("tx_wave_u%0d_%02h", k, d), bad_tx, 0);
        chk($sformatf("frame_done_u%0d_%02h", k, d), bad_fd, 0);
        chk($sformatf("busy_frame_u%0d_%02h", k, d), bad_busy, 0);
        @(negedge clk);
        chk($sformatf("busy_after_u%0d_%02h", k, d), busy_s[k], 0);
        chk($sformatf("empty_after_u%0d_%02h", k, d), fifo_empty[k], 1);
        chk($sformatf("rd_pulses_u%0d_%02h", k, d), rd_cnt[k] - rd0, 1);
        if (k == 0) begin
            chk("rx_count_u0", rx_q0.size(), 1);
            got = (rx_q0.size() > 0) ? rx_q0[0] : 8'hxx;
        end else begin
            chk("rx_count_u1", rx_q1.size(), 1);
            got = (rx_q1.size() > 0) ? rx_q1[0] : 8'hxx;
        end
        chk($sformatf("rx_byte_u%0d", k), got, d);
    endtask

    initial begin
        vec_t       vecs [5];
        logic [7:0] exp_q [$];
        logic [7:0] b;
        int rd0, frames, gap, gaps, gap_bad, bad, seen;
        bit in_gap;

        vecs[0] = '{0, 8'hA5, 10, 11'b11101001010};
        vecs[1] = '{1, 8'h07, 11, 11'b11000001110};
        vecs[2] = '{1, 8'h03, 11, 11'b10000000110};
        vecs[3] = '{0, 8'h00, 10, 11'b11000000000};
        vecs[4] = '{1, 8'hFF, 11, 11'b10111111110};

        rst_n = 1'b0; enable = 2'b11; wr_en = 2'b00;
        wr_data[0] = 8'h00; wr_data[1] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx_s, 2'b11);
        chk("reset_busy", busy_s, 2'b00);
        chk("reset_rd_en", fifo_rd_en, 2'b00);
        chk("reset_frame_done", frame_done_s, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frames, with and without parity.
        for (int i = 0; i < 5; i++) begin
            run_vector(vecs[i].unit, vecs[i].data, vecs[i].nbits, vecs[i].frame);
            repeat (3) @(negedge clk);
        end

        // Ten random bytes back to back.
        rd0 = rd_cnt[0]; clear_rx(); exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            push(0, b);
        end
        frames = 0; in_gap = 1'b0; gap = 0; gaps = 0; gap_bad = 0;
        for (int i = 0; i < 1000 && frames < 10; i++) begin
            @(negedge clk);
            if (frame_done_s[0]) begin
                frames++; in_gap = 1'b1; gap = 0;
            end else if (in_gap) begin
                if (tx_s[0]) gap++;
                else begin gaps++; if (gap != 2) gap_bad++; in_gap = 1'b0; end
            end
        end
        repeat (2 * CPB) @(negedge clk);
        chk("burst_frames", frames, 10);
        chk("burst_gap_count", gaps, 9);
        chk("burst_gap_len", gap_bad, 0);
        chk("burst_rd_pulses", rd_cnt[0] - rd0, 10);
        chk("burst_rx_count", rx_q0.size(), 10);
        for (int i = 0; i < 10 && i < rx_q0.size(); i++)
            chk($sformatf("burst_byte%0d", i), rx_q0[i], exp_q[i]);

        // Empty FIFO with enable held: nothing may move.
        rd0 = rd_cnt[0] + rd_cnt[1]; bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fifo_rd_en !== 2'b00 || busy_s !== 2'b00 || frame_done_s !== 2'b00 || tx_s !== 2'b11) bad++;
        end
        chk("idle_empty_quiet", bad, 0);
        chk("idle_empty_rd", rd_cnt[0] + rd_cnt[1] - rd0, 0);

        // Drop enable mid-frame with three bytes queued.
        clear_rx(); exp_q.delete(); rd0 = rd_cnt[0];
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            push(0, b);
        end
        repeat (6) @(negedge clk);
        enable[0] = 1'b0;
        seen = 0;
        for (int i = 0; i < 80 && seen == 0; i++) begin
            @(negedge clk);
            if (frame_done_s[0]) seen = 1;
        end
        chk("disable_frame1_done", seen, 1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fifo_rd_en[0] || busy_s[0] || !tx_s[0]) bad++;
        end
        chk("disable_idle", bad, 0);
        chk("disable_fifo_left", fcnt[0], 2);
        chk("disable_rd_pulses", rd_cnt[0] - rd0, 1);
        chk("disable_rx_count", rx_q0.size(), 1);
        if (rx_q0.size() > 0) chk("disable_rx_byte0", rx_q0[0], exp_q[0]);
        enable[0] = 1'b1;
        frames = 0;
        for (int i = 0; i < 300 && frames < 2; i++) begin
            @(negedge clk);
            if (frame_done_s[0]) frames++;
        end
        repeat (2 * CPB) @(negedge clk);
        chk("reenable_frames", frames, 2);
        chk("reenable_rx_count", rx_q0.size(), 3);
        for (int i = 1; i < 3 && i < rx_q0.size(); i++)
            chk($sformatf("reenable_byte%0d", i), rx_q0[i], exp_q[i]);

        // Reset during data bit 4 of 0xE5 (bit 4 is 0), then a clean frame.
        clear_rx();
        push(0, 8'hE5);
        seen = 0;
        for (int i = 0; i < 30 && tx_s[0] !== 1'b0; i++) @(negedge clk);
        repeat (21) @(negedge clk);
        chk("midreset_pre_tx", tx_s[0], 0);
        chk("midreset_pre_busy", busy_s[0], 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_tx", tx_s[0], 1);
        chk("midreset_busy", busy_s[0], 0);
        chk("midreset_rd_en", fifo_rd_en[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_rx();
        chk("midreset_fifo_empty", fifo_empty, 2'b11);
        run_vector(0, 8'h3C, 10, 11'b11001111000);

        chk("rx_frame_errors_u0", rx_err[0], 0);
        chk("rx_frame_errors_u1", rx_err[1], 0);
        chk("rd_en_violations", rd_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
